// File: rtl/hawk_axi_pkg.sv
// Shared AXI encodings, engine state types and the per-beat address sequencer
// used by both the write and read engines of the memory responder.
package hawk_axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Computed at 64 bits; callers zero-extend their address and truncate the result.
    function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [7:0]  len,
                                                  input logic [1:0]  burst);
        logic [63:0] step;
        logic [63:0] aligned;
        logic [63:0] wrap_mask;
        step      = 64'd1 << size;
        aligned   = addr & ~(step - 64'd1);
        wrap_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        case (burst)
            AXI_BURST_FIXED: axi_next_addr = addr;
            AXI_BURST_WRAP:  axi_next_addr = (addr & ~wrap_mask) | ((aligned + step) & wrap_mask);
            default:         axi_next_addr = aligned + step;
        endcase
    endfunction

    function automatic logic axi_burst_err(input logic [2:0] size,
                                           input logic [7:0] len,
                                           input logic [1:0] burst,
                                           input logic [2:0] max_size);
        logic bad_wrap;
        bad_wrap = (burst == AXI_BURST_WRAP) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        axi_burst_err = (size > max_size) || (burst == 2'b11) || bad_wrap;
    endfunction

endpackage

// File: rtl/hawk_axi_mem_responder_if.sv
// AXI4 AW/W/B/AR/R channel bundle (no lock/cache/prot/qos/region/user).
interface hawk_axi_mem_responder_if #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/hawk_axi_mem_1r1w.sv
// 1R1W byte-enable RAM with registered read port, read-first on same-word collision.
// Latency: read data valid the cycle after re; write lands at the clock edge.
// Backpressure: none; the read register holds its value while re is low.
module hawk_axi_mem_1r1w #(
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         re,
    input  logic [$clog2(MEM_WORDS)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/hawk_axi_mem_responder.sv
// AXI4 slave serving bursts from a local 1R1W memory; independent write and read engines.
// Latency: rvalid one cycle after AR handshake, full-rate beats; B one cycle after last W.
// Backpressure: R beats and B held stable until rready/bready; one burst per engine in flight.
module hawk_axi_mem_responder
    import hawk_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int ADDR_WIDTH = 40,
    parameter int ID_WIDTH   = 6,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    hawk_axi_mem_responder_if.slave    s_axi
);
    localparam int         BYTE_LSB = $clog2(STRB_WIDTH);
    localparam int         MEM_AW   = $clog2(MEM_WORDS);
    localparam logic [2:0] MAX_SIZE = 3'(BYTE_LSB);

    w_state_t              w_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst, w_resp;
    logic                  w_err, aw_hs, w_hs, w_end;

    r_state_t              r_state, r_state_nxt;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err, ar_hs, r_hs, r_last, mem_re;
    logic [MEM_AW-1:0]     mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always_comb begin
        w_state_nxt   = w_state;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        w_end         = s_axi.wlast || (w_cnt == w_len);
        case (w_state)
            W_IDLE: begin
                s_axi.awready = 1'b1;
                aw_hs         = s_axi.awvalid;
                if (aw_hs) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                w_hs         = s_axi.wvalid;
                if (w_hs && w_end) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_resp  <= AXI_RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_id    <= s_axi.awid;
                w_addr  <= s_axi.awaddr;
                w_len   <= s_axi.awlen;
                w_size  <= s_axi.awsize;
                w_burst <= s_axi.awburst;
                w_cnt   <= '0;
                w_err   <= axi_burst_err(s_axi.awsize, s_axi.awlen, s_axi.awburst, MAX_SIZE);
            end
            if (w_hs) begin
                w_addr <= ADDR_WIDTH'(axi_next_addr(64'(w_addr), w_size, w_len, w_burst));
                w_cnt  <= w_cnt + 8'd1;
                // Clean termination needs wlast to coincide exactly with beat len.
                if (w_end) w_resp <= (w_err || !(s_axi.wlast && (w_cnt == w_len)))
                                     ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

    assign s_axi.bid   = w_id;
    assign s_axi.bresp = w_resp;

    // r_addr always holds the address of the next beat to fetch.
    always_comb begin
        r_state_nxt   = r_state;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        ar_hs         = 1'b0;
        r_hs          = 1'b0;
        mem_re        = 1'b0;
        mem_raddr     = r_addr[BYTE_LSB +: MEM_AW];
        r_last        = (r_state == R_DATA) && (r_cnt == r_len);
        case (r_state)
            R_IDLE: begin
                s_axi.arready = 1'b1;
                ar_hs         = s_axi.arvalid;
                if (ar_hs) begin
                    mem_re      = 1'b1;
                    mem_raddr   = s_axi.araddr[BYTE_LSB +: MEM_AW];
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                s_axi.rvalid = 1'b1;
                r_hs         = s_axi.rready;
                if (r_hs) begin
                    if (r_last) r_state_nxt = R_IDLE;
                    else        mem_re      = 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_id    <= s_axi.arid;
                r_addr  <= ADDR_WIDTH'(axi_next_addr(64'(s_axi.araddr), s_axi.arsize,
                                                     s_axi.arlen, s_axi.arburst));
                r_len   <= s_axi.arlen;
                r_size  <= s_axi.arsize;
                r_burst <= s_axi.arburst;
                r_cnt   <= '0;
                r_err   <= axi_burst_err(s_axi.arsize, s_axi.arlen, s_axi.arburst, MAX_SIZE);
            end
            if (r_hs && !r_last) begin
                r_addr <= ADDR_WIDTH'(axi_next_addr(64'(r_addr), r_size, r_len, r_burst));
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    assign s_axi.rid   = r_id;
    assign s_axi.rlast = r_last;
    assign s_axi.rresp = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign s_axi.rdata = r_err ? '0 : mem_rdata;

    hawk_axi_mem_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_hs && !w_err),
        .waddr (w_addr[BYTE_LSB +: MEM_AW]),
        .wdata (s_axi.wdata),
        .wstrb (s_axi.wstrb),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_hawk_axi_mem_responder.sv
// Directed bench: burst table (writes then read-backs) plus read-first and mid-burst reset sequences.
module tb_hawk_axi_mem_responder;
    import hawk_axi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hawk_axi_mem_responder_if #(.ID_WIDTH(6), .ADDR_WIDTH(40), .DATA_WIDTH(64)) ifc ();

    hawk_axi_mem_responder #(
        .DATA_WIDTH (64),
        .STRB_WIDTH (8),
        .ADDR_WIDTH (40),
        .ID_WIDTH   (6),
        .MEM_WORDS  (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (ifc)
    );

    typedef struct {
        bit              w;
        logic [5:0]      id;
        logic [39:0]     addr;
        logic [7:0]      len;
        logic [2:0]      sz;
        logic [1:0]      bst;
        logic [7:0]      strb;
        int              wlast_at;
        logic [63:0]     seed;
        bit              stall;
        logic [1:0]      resp;
        logic [7:0][63:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit w, input logic [5:0] id, input logic [39:0] addr,
                                input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bst,
                                input logic [7:0] strb, input int wlast_at, input logic [63:0] seed,
                                input bit stall, input logic [1:0] resp, input logic [7:0][63:0] exp);
        vec_t v;
        v.w = w; v.id = id; v.addr = addr; v.len = len; v.sz = sz; v.bst = bst;
        v.strb = strb; v.wlast_at = wlast_at; v.seed = seed; v.stall = stall;
        v.resp = resp; v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0][63:0] bt(input logic [63:0] b0, b1, b2, b3, b4, b5, b6, b7);
        bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
        bt[4] = b4; bt[5] = b5; bt[6] = b6; bt[7] = b7;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_write(input int tag, input logic [5:0] id, input logic [39:0] addr,
                            input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bst,
                            input logic [7:0] strb, input int wlast_at, input logic [63:0] seed,
                            input logic [1:0] exp_resp);
        int n;
        int nb;
        nb = ((wlast_at < int'(len)) ? wlast_at : int'(len)) + 1;
        ifc.awid = id; ifc.awaddr = addr; ifc.awlen = len; ifc.awsize = sz; ifc.awburst = bst;
        ifc.awvalid = 1'b1;
        n = 0;
        while (!ifc.awready && n < 50) begin cyc(); n++; end
        chk($sformatf("%0d:awready", tag), ifc.awready, 1);
        cyc();
        ifc.awvalid = 1'b0;
        for (int k = 0; k < nb; k++) begin
            ifc.wvalid = 1'b1;
            ifc.wdata  = seed + 64'(k);
            ifc.wstrb  = strb;
            ifc.wlast  = (k == wlast_at);
            n = 0;
            while (!ifc.wready && n < 50) begin cyc(); n++; end
            chk($sformatf("%0d:wready_beat%0d", tag, k), ifc.wready, 1);
            cyc();
        end
        ifc.wvalid = 1'b0;
        ifc.wlast  = 1'b0;
        chk($sformatf("%0d:wready_after_last", tag), ifc.wready, 0);
        ifc.bready = 1'b1;
        n = 0;
        while (!ifc.bvalid && n < 50) begin cyc(); n++; end
        chk($sformatf("%0d:bvalid", tag), ifc.bvalid, 1);
        chk($sformatf("%0d:bid", tag), ifc.bid, id);
        chk($sformatf("%0d:bresp", tag), ifc.bresp, exp_resp);
        cyc();
        ifc.bready = 1'b0;
        chk($sformatf("%0d:awready_after_b", tag), ifc.awready, 1);
    endtask

    task automatic do_read(input int tag, input logic [5:0] id, input logic [39:0] addr,
                           input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bst,
                           input bit stall, input logic [1:0] exp_resp, input logic [7:0][63:0] exp);
        int          n, cnt, t, gaps;
        logic [63:0] hd;
        logic [5:0]  hid;
        logic        hl, rr;
        bit          held;
        ifc.arid = id; ifc.araddr = addr; ifc.arlen = len; ifc.arsize = sz; ifc.arburst = bst;
        ifc.arvalid = 1'b1;
        n = 0;
        while (!ifc.arready && n < 50) begin cyc(); n++; end
        chk($sformatf("%0d:arready", tag), ifc.arready, 1);
        cyc();
        ifc.arvalid = 1'b0;
        chk($sformatf("%0d:rvalid_first", tag), ifc.rvalid, 1);
        cnt = 0; t = 0; gaps = 0; held = 0; hd = '0; hid = '0; hl = 1'b0;
        while (cnt <= int'(len) && t < 300) begin
            rr = stall ? (t % 3 == 0) : 1'b1;
            ifc.rready = rr;
            if (!ifc.rvalid) begin
                gaps++;
            end else begin
                if (held) begin
                    chk($sformatf("%0d:stall_rdata", tag), ifc.rdata, hd);
                    chk($sformatf("%0d:stall_rid", tag), ifc.rid, hid);
                    chk($sformatf("%0d:stall_rlast", tag), ifc.rlast, hl);
                end
                if (rr) begin
                    chk($sformatf("%0d:rdata_beat%0d", tag, cnt), ifc.rdata, exp[cnt]);
                    chk($sformatf("%0d:rid_beat%0d", tag, cnt), ifc.rid, id);
                    chk($sformatf("%0d:rresp_beat%0d", tag, cnt), ifc.rresp, exp_resp);
                    chk($sformatf("%0d:rlast_beat%0d", tag, cnt), ifc.rlast, (cnt == int'(len)));
                    cnt++;
                    held = 0;
                end else begin
                    held = 1;
                    hd = ifc.rdata; hid = ifc.rid; hl = ifc.rlast;
                end
            end
            cyc();
            t++;
        end
        ifc.rready = 1'b0;
        chk($sformatf("%0d:beat_count", tag), cnt, int'(len) + 1);
        if (!stall) chk($sformatf("%0d:rvalid_gaps", tag), gaps, 0);
        chk($sformatf("%0d:rvalid_after_last", tag), ifc.rvalid, 0);
        chk($sformatf("%0d:arready_after_last", tag), ifc.arready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0;
        ifc.awvalid = 1'b0; ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0;
        ifc.bready = 1'b0; ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0;
        ifc.arburst = '0; ifc.arvalid = 1'b0; ifc.rready = 1'b0;
        repeat (3) cyc();
        chk("rst:awready", ifc.awready, 1);
        chk("rst:arready", ifc.arready, 1);
        chk("rst:wready", ifc.wready, 0);
        chk("rst:bvalid", ifc.bvalid, 0);
        chk("rst:rvalid", ifc.rvalid, 0);
        chk("rst:rlast", ifc.rlast, 0);
        chk("rst:bid", ifc.bid, 0);
        chk("rst:rid", ifc.rid, 0);
        chk("rst:bresp", ifc.bresp, 0);
        chk("rst:rresp", ifc.rresp, 0);
        chk("rst:rdata", ifc.rdata, 0);
        rst_n = 1'b1;
        cyc();

        tbl.push_back(mk(1, 5,  40'h100, 3, 3, AXI_BURST_INCR, 8'hFF, 3,   64'hA0, 0, AXI_RESP_OKAY, '0));
        tbl.push_back(mk(0, 7,  40'h100, 3, 3, AXI_BURST_INCR, 0, 0, 0, 0, AXI_RESP_OKAY,
                         bt(64'hA0, 64'hA1, 64'hA2, 64'hA3, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 2,  40'h118, 3, 3, AXI_BURST_WRAP, 0, 0, 0, 0, AXI_RESP_OKAY,
                         bt(64'hA3, 64'hA0, 64'hA1, 64'hA2, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1,  40'h200, 3, 3, AXI_BURST_INCR, 8'hFF, 1,   64'hB0, 0, AXI_RESP_SLVERR, '0));
        tbl.push_back(mk(0, 3,  40'h200, 1, 3, AXI_BURST_INCR, 0, 0, 0, 0, AXI_RESP_OKAY,
                         bt(64'hB0, 64'hB1, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 4,  40'h100, 3, 4, AXI_BURST_INCR, 0, 0, 0, 0, AXI_RESP_SLVERR, '0));
        tbl.push_back(mk(1, 6,  40'h100, 1, 4, AXI_BURST_INCR, 8'hFF, 1,   64'hC0, 0, AXI_RESP_SLVERR, '0));
        tbl.push_back(mk(0, 8,  40'h100, 1, 3, AXI_BURST_INCR, 0, 0, 0, 0, AXI_RESP_OKAY,
                         bt(64'hA0, 64'hA1, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 9,  40'h400, 3, 3, AXI_BURST_INCR, 8'hFF, 255, 64'hD0, 0, AXI_RESP_SLVERR, '0));
        tbl.push_back(mk(0, 10, 40'hF0_0000_2400, 3, 3, AXI_BURST_INCR, 0, 0, 0, 0, AXI_RESP_OKAY,
                         bt(64'hD0, 64'hD1, 64'hD2, 64'hD3, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 12, 40'h500, 2, 3, AXI_BURST_FIXED, 8'hFF, 2,  64'hE0, 0, AXI_RESP_OKAY, '0));
        tbl.push_back(mk(0, 13, 40'h500, 2, 3, AXI_BURST_FIXED, 0, 0, 0, 0, AXI_RESP_OKAY,
                         bt(64'hE2, 64'hE2, 64'hE2, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 14, 40'h100, 0, 3, 2'b11, 0, 0, 0, 0, AXI_RESP_SLVERR, '0));
        tbl.push_back(mk(0, 15, 40'h100, 2, 3, AXI_BURST_WRAP, 0, 0, 0, 0, AXI_RESP_SLVERR, '0));
        tbl.push_back(mk(1, 16, 40'h600, 7, 3, AXI_BURST_INCR, 8'hFF, 7,   64'hF0, 0, AXI_RESP_OKAY, '0));
        tbl.push_back(mk(0, 17, 40'h600, 7, 3, AXI_BURST_INCR, 0, 0, 0, 1, AXI_RESP_OKAY,
                         bt(64'hF0, 64'hF1, 64'hF2, 64'hF3, 64'hF4, 64'hF5, 64'hF6, 64'hF7)));
        tbl.push_back(mk(1, 0,  40'h108, 0, 2, AXI_BURST_INCR, 8'h0F, 0, 64'h1111_2222_3333_4444, 0,
                         AXI_RESP_OKAY, '0));
        tbl.push_back(mk(0, 18, 40'h108, 0, 3, AXI_BURST_INCR, 0, 0, 0, 0, AXI_RESP_OKAY,
                         bt(64'h0000_0000_3333_4444, 0, 0, 0, 0, 0, 0, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].w)
                do_write(i, tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].sz, tbl[i].bst,
                         tbl[i].strb, tbl[i].wlast_at, tbl[i].seed, tbl[i].resp);
            else
                do_read(i, tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].sz, tbl[i].bst,
                        tbl[i].stall, tbl[i].resp, tbl[i].exp);
        end

        // W beat and AR hit word 0x20 on the same edge: the read must see the old value.
        ifc.awid = 6'd11; ifc.awaddr = 40'h100; ifc.awlen = 8'd0; ifc.awsize = 3'd3;
        ifc.awburst = AXI_BURST_INCR; ifc.awvalid = 1'b1;
        chk("rf:awready", ifc.awready, 1);
        cyc();
        ifc.awvalid = 1'b0;
        chk("rf:wready", ifc.wready, 1);
        ifc.wvalid = 1'b1; ifc.wdata = 64'h5555; ifc.wstrb = 8'hFF; ifc.wlast = 1'b1;
        ifc.arid = 6'd12; ifc.araddr = 40'h100; ifc.arlen = 8'd0; ifc.arsize = 3'd3;
        ifc.arburst = AXI_BURST_INCR; ifc.arvalid = 1'b1;
        chk("rf:arready", ifc.arready, 1);
        cyc();
        ifc.wvalid = 1'b0; ifc.wlast = 1'b0; ifc.arvalid = 1'b0;
        chk("rf:rvalid", ifc.rvalid, 1);
        chk("rf:old_data", ifc.rdata, 64'hA0);
        chk("rf:rid", ifc.rid, 12);
        chk("rf:bvalid", ifc.bvalid, 1);
        chk("rf:bid", ifc.bid, 11);
        chk("rf:bresp", ifc.bresp, AXI_RESP_OKAY);
        ifc.rready = 1'b1; ifc.bready = 1'b1;
        cyc();
        ifc.rready = 1'b0; ifc.bready = 1'b0;
        chk("rf:rvalid_done", ifc.rvalid, 0);
        chk("rf:bvalid_done", ifc.bvalid, 0);
        do_read(100, 6'd20, 40'h100, 8'd0, 3'd3, AXI_BURST_INCR, 0, AXI_RESP_OKAY,
                bt(64'h5555, 0, 0, 0, 0, 0, 0, 0));

        // Reset while beat 2 of an 8-beat read is presented.
        ifc.arid = 6'd21; ifc.araddr = 40'h600; ifc.arlen = 8'd7; ifc.arsize = 3'd3;
        ifc.arburst = AXI_BURST_INCR; ifc.arvalid = 1'b1;
        chk("mr:arready", ifc.arready, 1);
        cyc();
        ifc.arvalid = 1'b0;
        ifc.rready = 1'b1;
        cyc();
        cyc();
        ifc.rready = 1'b0;
        chk("mr:beat2_data", ifc.rdata, 64'hF2);
        chk("mr:beat2_vld", ifc.rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("mr:rvalid_in_rst", ifc.rvalid, 0);
        chk("mr:rlast_in_rst", ifc.rlast, 0);
        chk("mr:rdata_in_rst", ifc.rdata, 0);
        chk("mr:rid_in_rst", ifc.rid, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("mr:arready_after", ifc.arready, 1);
        chk("mr:awready_after", ifc.awready, 1);
        chk("mr:rvalid_after", ifc.rvalid, 0);
        do_read(200, 6'd22, 40'h608, 8'd1, 3'd3, AXI_BURST_INCR, 0, AXI_RESP_OKAY,
                bt(64'hF1, 64'hF2, 0, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
